// File: rtl/clk_step_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_ctrl_defs (package)
// Purpose  : Shared state encodings, debounce defaults and prescaler helper
//            for the CPU clock-enable / single-step controller.
// Revision : 1.0 - initial release
// ============================================================================
package clk_ctrl_defs;

  // FSM encoding is visible on the state output, so values are fixed
  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10
  } state_t;

  // 5 ms of stable button level at 200 MHz
  localparam int DB_CYCLES_DEFAULT = 1000000;
  localparam int DB_W_DEFAULT      = 20;

  // Low-order ones mask selecting the prescaler tap; sel=0 yields an empty mask
  function automatic logic [31:0] tap_mask(input logic [4:0] sel);
    return (32'd1 << sel) - 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_step_ctrl_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Purpose  : Two-flop synchronizer followed by a level debouncer. The output
//            only moves after the synchronized input has disagreed with it
//            for DB_CYCLES consecutive clocks.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce
  import clk_ctrl_defs::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int DB_W      = DB_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_db;
  logic [DB_W-1:0] r_cnt;

  // Synchronize the raw pin, then count consecutive disagreeing cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_db) begin
        // The edge closing the DB_CYCLES-th disagreeing cycle commits the level
        if (r_cnt == DB_W'(DB_CYCLES - 1)) begin
          r_db  <= r_sync2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign dout = r_db;

endmodule
`default_nettype wire

// File: rtl/clk_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clk_step_ctrl
// Purpose  : CPU clock-enable generator with free-run (prescaled) and
//            debounced single-step modes, breakpoint halt, and a running
//            count of issued enables. No clock gating: only cpu_ce pulses.
// Revision : 1.0 - initial release
// ============================================================================
module clk_step_ctrl
  import clk_ctrl_defs::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int DB_W      = DB_W_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_en,
  input  logic        step_btn,
  input  logic [4:0]  div_sel,
  input  logic        halt,
  output logic        cpu_ce,
  output logic [31:0] cycle_cnt,
  output logic [1:0]  state
);

  logic        w_btn_db;
  logic        w_tick;
  logic        w_ce;
  logic [31:0] w_mask;
  logic        r_btn_db_q;
  logic        r_step_req;
  state_t      r_state;
  logic [31:0] r_pre_cnt;
  logic [31:0] r_cycle_cnt;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES),
    .DB_W      (DB_W)
  ) u_btn_debounce (
    .clk  (clk),
    .rst  (rst),
    .din  (step_btn),
    .dout (w_btn_db)
  );

  // One-cycle step request on each debounced rising edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_btn_db_q <= 1'b0;
      r_step_req <= 1'b0;
    end else begin
      r_btn_db_q <= w_btn_db;
      r_step_req <= w_btn_db & ~r_btn_db_q;
    end
  end

  // Mode FSM; a step request outside HALT is simply ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_HALT;
    end else begin
      case (r_state)
        ST_HALT: begin
          if (run_en && !halt)          r_state <= ST_RUN;
          else if (!run_en && r_step_req) r_state <= ST_STEP;
        end
        ST_RUN: begin
          if (!run_en || halt) r_state <= ST_HALT;
        end
        ST_STEP: r_state <= ST_HALT;
        default: r_state <= ST_HALT;
      endcase
    end
  end

  // Prescaler free-runs only while in RUN so each run burst starts aligned
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre_cnt <= '0;
    end else if (r_state == ST_RUN) begin
      r_pre_cnt <= r_pre_cnt + 32'd1;
    end else begin
      r_pre_cnt <= '0;
    end
  end

  // div_sel is applied live to the running count, so a change never resets it
  assign w_mask = tap_mask(div_sel);
  assign w_tick = ((r_pre_cnt & w_mask) == w_mask);

  // rst masks the enable so the edge that samples reset never clocks the CPU
  assign w_ce = !rst &&
                ((r_state == ST_STEP) ||
                 ((r_state == ST_RUN) && w_tick && run_en && !halt));

  // Count every issued enable, wrapping naturally at 32 bits
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_cnt <= '0;
    end else if (w_ce) begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
    end
  end

  assign cpu_ce    = w_ce;
  assign cycle_cnt = r_cycle_cnt;
  assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_clk_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_step_ctrl
// Purpose  : Directed bench for clk_step_ctrl with a pulse scoreboard: each
//            expected cpu_ce pulse is queued with the cycle_cnt value it
//            should carry, and a monitor pops one entry per observed pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_step_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run_en = 1'b0;
  logic        step_btn = 1'b0;
  logic [4:0]  div_sel = 5'd0;
  logic        halt = 1'b0;
  logic        cpu_ce;
  logic [31:0] cycle_cnt;
  logic [1:0]  state;

  int          total = 0;
  int          bad = 0;
  logic [31:0] sb[$];

  clk_step_ctrl #(
    .DB_CYCLES (4),
    .DB_W      (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run_en    (run_en),
    .step_btn  (step_btn),
    .div_sel   (div_sel),
    .halt      (halt),
    .cpu_ce    (cpu_ce),
    .cycle_cnt (cycle_cnt),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press();
    step_btn = 1'b1;
    cyc(12);
    step_btn = 1'b0;
    cyc(12);
  endtask

  // Pulse monitor: every cpu_ce must match the oldest queued expectation
  always @(negedge clk) begin
    if (cpu_ce === 1'b1) begin
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_ce observed_cnt=%0h expected=no_pulse", cycle_cnt);
      end
      if (sb.size() != 0) begin
        logic [31:0] e;
        e = sb.pop_front();
        total++;
        assert (cycle_cnt === e) else begin
          bad++;
          $error("FAIL pulse_cnt observed=%0h expected=%0h", cycle_cnt, e);
        end
      end
    end
  end

  initial begin
    bit found;

    // Reset state
    cyc(3);
    chk("rst_ce", {31'd0, cpu_ce}, 32'd0);
    chk("rst_cnt", cycle_cnt, 32'd0);
    chk("rst_state", {30'd0, state}, 32'd0);
    rst = 1'b0;
    cyc(2);

    // Bouncing button then a clean hold: exactly one step
    sb.push_back(32'd0);
    cyc(2);
    step_btn = 1'b1; cyc(2);
    step_btn = 1'b0; cyc(2);
    step_btn = 1'b1; cyc(10);
    step_btn = 1'b0; cyc(12);
    chk("bounce_cnt", cycle_cnt, 32'd1);
    chk("bounce_sb", sb.size(), 32'd0);
    chk("bounce_state", {30'd0, state}, 32'd0);

    // Free run at clk/4 for 40 cycles
    run_en  = 1'b1;
    div_sel = 5'd2;
    for (int i = 1; i <= 10; i++) sb.push_back(32'(i));
    cyc(41);
    chk("run_state", {30'd0, state}, 32'd1);
    chk("run_cnt", cycle_cnt, 32'd11);
    chk("run_sb", sb.size(), 32'd0);

    // div_sel=0 pulses every cycle; halt overrides the tick
    div_sel = 5'd0;
    sb.push_back(32'd11);
    cyc(1);
    halt = 1'b1;
    #1;
    chk("halt_ce", {31'd0, cpu_ce}, 32'd0);
    cyc(1);
    chk("halt_state", {30'd0, state}, 32'd0);
    chk("halt_cnt", cycle_cnt, 32'd12);
    run_en = 1'b0;
    cyc(3);
    chk("halt_frozen", cycle_cnt, 32'd12);

    // Step past a breakpoint while halt is held
    sb.push_back(32'd12);
    press();
    chk("bp_step_cnt", cycle_cnt, 32'd13);
    chk("bp_step_sb", sb.size(), 32'd0);

    // Press during RUN is dropped (tap too slow to tick here)
    halt    = 1'b0;
    div_sel = 5'd31;
    run_en  = 1'b1;
    cyc(1);
    chk("drop_state", {30'd0, state}, 32'd1);
    press();
    chk("drop_cnt", cycle_cnt, 32'd13);
    run_en = 1'b0;
    cyc(4);
    chk("drop_halt", {30'd0, state}, 32'd0);
    chk("drop_cnt2", cycle_cnt, 32'd13);

    // Counter wrap on a single step
    force dut.r_cycle_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_cycle_cnt;
    sb.push_back(32'hFFFF_FFFF);
    press();
    chk("wrap_cnt", cycle_cnt, 32'd0);
    chk("wrap_sb", sb.size(), 32'd0);

    // Reset landing in the STEP cycle suppresses the pulse
    sb.push_back(32'd0);
    press();
    chk("pre_rst_cnt", cycle_cnt, 32'd1);
    step_btn = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(1);
      if (state === 2'b10) found = 1'b1;
    end
    chk("step_seen", {31'd0, found}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_step_ce", {31'd0, cpu_ce}, 32'd0);
    cyc(1);
    chk("rst_step_state", {30'd0, state}, 32'd0);
    chk("rst_step_cnt", cycle_cnt, 32'd0);
    cyc(2);

    // Button held through reset release yields one step later
    sb.push_back(32'd0);
    rst = 1'b0;
    cyc(12);
    step_btn = 1'b0;
    cyc(12);
    chk("held_cnt", cycle_cnt, 32'd1);
    chk("held_sb", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clk_step_ctrl.md
CLK_STEP_CTRL -- requirements
Module: clk_step_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 1000000, consecutive stable cycles required to accept a new step_btn level (5 ms at 200 MHz).
REQ-002 Parameter DB_W, default 20, width of the debounce counter; DB_W SHALL hold DB_CYCLES.
REQ-003 clk  input  1  single system clock (200 MHz single-ended); all logic on posedge clk.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 run_en  input  1  1 = free-run mode, 0 = single-step mode; level, synchronous to clk.
REQ-006 step_btn  input  1  raw board push-button, asynchronous, bouncing.
REQ-007 div_sel  input  5  prescaler tap; run-mode enable rate = clk / 2^div_sel.
REQ-008 halt  input  1  CPU halt request (breakpoint), level, synchronous.
REQ-009 cpu_ce  output  1  CPU clock-enable, one-cycle pulses.
REQ-010 cycle_cnt  output  32  count of cpu_ce pulses issued.
REQ-011 state  output  2  current FSM state: HALT=2'b00, RUN=2'b01, STEP=2'b10.

Function
REQ-012 step_btn SHALL pass through a 2-FF synchronizer before any other use.
REQ-013 Debounce: btn_db SHALL take the synchronized level only after that level differs from btn_db for DB_CYCLES consecutive cycles; any reversion clears the counter.
REQ-014 step_req SHALL be a registered one-cycle pulse on each 0->1 transition of btn_db.
REQ-015 Prescaler: 32-bit pre_cnt SHALL increment every cycle in RUN and clear to 0 in every other state.
REQ-016 tick SHALL be high when pre_cnt[div_sel-1:0] are all ones; div_sel=0 gives tick every cycle in RUN.
REQ-017 div_sel changes SHALL take effect on the next comparison without clearing pre_cnt.
REQ-018 HALT: go to RUN when run_en=1 and halt=0; otherwise go to STEP when run_en=0 and step_req=1; otherwise stay.
REQ-019 RUN: go to HALT when run_en=0 or halt=1; otherwise stay.
REQ-020 STEP: always go to HALT the following cycle.
REQ-021 cpu_ce = (state==STEP) OR (state==RUN AND tick AND run_en AND NOT halt); decoded from registered signals only.
REQ-022 Single-step latency: step_req high at cycle n -> state=STEP and cpu_ce=1 at cycle n+1 -> cpu_ce=0 at n+2; exactly one pulse per press.
REQ-023 Single-step SHALL be allowed while halt=1, so software can step past a breakpoint.
REQ-024 step_req arriving in RUN or STEP SHALL be dropped, not queued.
REQ-025 halt and tick in the same cycle: halt wins; no cpu_ce is issued.
REQ-026 cycle_cnt SHALL increment by 1 in every cycle cpu_ce=1, wrapping 0xFFFFFFFF -> 0x00000000.

Reset
REQ-027 When rst=1 is sampled: state=HALT; cpu_ce=0; cycle_cnt=0; pre_cnt=0; sync FFs, btn_db, debounce counter and step_req all 0.
REQ-028 Reset mid-RUN or mid-STEP SHALL suppress cpu_ce from the first clock edge that samples rst=1; no partial pulse is issued.
REQ-029 A button held through reset deassertion SHALL produce one step_req, after DB_CYCLES cycles.

Structure
REQ-030 Shared header clk_ctrl_defs SHALL hold the state encodings and the DB_CYCLES default.
REQ-031 Synchronizer plus debouncer SHALL be one sub-module, btn_debounce (ports clk, rst, din, dout).
REQ-032 FSM, prescaler, ce decode and cycle_cnt SHALL live in clk_step_ctrl; no clock gating and no generated clocks.

Verification (DB_CYCLES=4)
REQ-033 Bounce step_btn 0/1/0/1 at 2-cycle intervals, then hold 1 for 10 cycles with run_en=0 -> exactly one cpu_ce pulse; cycle_cnt=1.
REQ-034 run_en=1, div_sel=2, halt=0 for 40 cycles -> cpu_ce every 4th cycle; cycle_cnt=10; state=RUN.
REQ-035 In RUN with div_sel=0, raise halt -> state=HALT next cycle; cpu_ce=0 in the halt cycle onward; cycle_cnt frozen.
REQ-036 halt=1, run_en=0, one clean press -> one cpu_ce; then press during RUN -> no extra pulse.
REQ-037 Preload cycle_cnt=0xFFFFFFFF (force), issue one step -> cycle_cnt=0x00000000.
REQ-038 Assert rst in the STEP cycle -> cpu_ce=0 at that edge; state=HALT; cycle_cnt=0.
